// File: rtl/mem_access_stage.sv
// MEM stage + MEM/WB register: issues loads/stores over req/ack, stalls upstream while BUSY, aborts after TIMEOUT.
// Optional MEM_ALIGN_CHECK_EN: misaligned memory ops are squashed and flagged on align_err.
module mem_access_stage #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic        MemWrite,
   input  logic        MemToReg,
   input  logic        RegWrite,
   input  logic        FlagWrite,
   input  logic [4:0]  Rd,
   input  logic [63:0] alu_result,
   input  logic [63:0] Db,
   output logic        stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   input  logic [63:0] mem_rdata,
   input  logic        mem_ack,
   output logic        wb_valid,
   output logic        RegWrite_wb,
   output logic        FlagWrite_wb,
   output logic [4:0]  Rd_wb,
   output logic [63:0] wb_data,
`ifdef MEM_ALIGN_CHECK_EN
   output logic        align_err,
`endif
   output logic        mem_err
);

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t      r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

   logic        r_mem_req, w_mem_req_nxt;
   logic        r_mem_we, w_mem_we_nxt;
   logic [63:0] r_mem_addr, w_mem_addr_nxt;
   logic [63:0] r_mem_wdata, w_mem_wdata_nxt;

   logic        r_is_load, w_is_load_nxt;
   logic        r_rw, w_rw_nxt;
   logic        r_fw, w_fw_nxt;
   logic [4:0]  r_rd, w_rd_nxt;

   logic        r_wb_valid, w_wb_valid_nxt;
   logic        r_rw_wb, w_rw_wb_nxt;
   logic        r_fw_wb, w_fw_wb_nxt;
   logic [4:0]  r_rd_wb, w_rd_wb_nxt;
   logic [63:0] r_wb_data, w_wb_data_nxt;
   logic        r_mem_err, w_mem_err_nxt;

   logic        w_accept;
   logic        w_is_mem;
   logic        w_misaligned;
   logic        w_timeout;

`ifdef MEM_ALIGN_CHECK_EN
   logic        r_align_err, w_align_err_nxt;
   assign w_misaligned = |alu_result[2:0];
   assign align_err    = r_align_err;
`else
   assign w_misaligned = 1'b0;
`endif

   assign stall     = (r_state == S_BUSY);
   assign w_accept  = in_valid & ~stall;
   assign w_is_mem  = MemWrite | MemToReg;
   assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_mem_req_nxt   = r_mem_req;
      w_mem_we_nxt    = r_mem_we;
      w_mem_addr_nxt  = r_mem_addr;
      w_mem_wdata_nxt = r_mem_wdata;
      w_is_load_nxt   = r_is_load;
      w_rw_nxt        = r_rw;
      w_fw_nxt        = r_fw;
      w_rd_nxt        = r_rd;
      w_wb_valid_nxt  = 1'b0;
      w_rw_wb_nxt     = r_rw_wb;
      w_fw_wb_nxt     = r_fw_wb;
      w_rd_wb_nxt     = r_rd_wb;
      w_wb_data_nxt   = r_wb_data;
      w_mem_err_nxt   = r_mem_err;
`ifdef MEM_ALIGN_CHECK_EN
      w_align_err_nxt = r_align_err;
`endif

      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (!w_is_mem) begin
                  w_wb_valid_nxt = 1'b1;
                  w_rw_wb_nxt    = RegWrite;
                  w_fw_wb_nxt    = FlagWrite;
                  w_rd_wb_nxt    = Rd;
                  w_wb_data_nxt  = alu_result;
               end else if (w_misaligned) begin
                  // Squashed op still retires so the pipeline sees a slot, but with no side effects
                  w_wb_valid_nxt  = 1'b1;
                  w_rw_wb_nxt     = 1'b0;
                  w_fw_wb_nxt     = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
                  w_align_err_nxt = 1'b1;
`endif
               end else begin
                  w_state_nxt     = S_BUSY;
                  w_cnt_nxt       = '0;
                  w_mem_req_nxt   = 1'b1;
                  w_mem_we_nxt    = MemWrite;
                  w_mem_addr_nxt  = alu_result;
                  w_mem_wdata_nxt = Db;
                  w_is_load_nxt   = MemToReg & ~MemWrite;
                  w_rw_nxt        = RegWrite;
                  w_fw_nxt        = FlagWrite;
                  w_rd_nxt        = Rd;
               end
            end
         end
         S_BUSY: begin
            // Ack takes priority over the timeout on the final wait cycle
            if (mem_ack) begin
               w_state_nxt    = S_IDLE;
               w_mem_req_nxt  = 1'b0;
               w_wb_valid_nxt = 1'b1;
               w_fw_wb_nxt    = r_fw;
               w_rd_wb_nxt    = r_rd;
               if (r_is_load) begin
                  w_rw_wb_nxt   = r_rw;
                  w_wb_data_nxt = mem_rdata;
               end else begin
                  w_rw_wb_nxt   = 1'b0;
                  w_wb_data_nxt = r_mem_addr;
               end
            end else if (w_timeout) begin
               w_state_nxt    = S_IDLE;
               w_mem_req_nxt  = 1'b0;
               w_mem_err_nxt  = 1'b1;
               w_wb_valid_nxt = 1'b1;
               w_rw_wb_nxt    = 1'b0;
               w_fw_wb_nxt    = 1'b0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt       <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_is_load   <= 1'b0;
         r_rw        <= 1'b0;
         r_fw        <= 1'b0;
         r_rd        <= '0;
         r_wb_valid  <= 1'b0;
         r_rw_wb     <= 1'b0;
         r_fw_wb     <= 1'b0;
         r_rd_wb     <= '0;
         r_wb_data   <= '0;
         r_mem_err   <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
         r_align_err <= 1'b0;
`endif
      end else begin
         r_cnt       <= w_cnt_nxt;
         r_mem_req   <= w_mem_req_nxt;
         r_mem_we    <= w_mem_we_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
         r_mem_wdata <= w_mem_wdata_nxt;
         r_is_load   <= w_is_load_nxt;
         r_rw        <= w_rw_nxt;
         r_fw        <= w_fw_nxt;
         r_rd        <= w_rd_nxt;
         r_wb_valid  <= w_wb_valid_nxt;
         r_rw_wb     <= w_rw_wb_nxt;
         r_fw_wb     <= w_fw_wb_nxt;
         r_rd_wb     <= w_rd_wb_nxt;
         r_wb_data   <= w_wb_data_nxt;
         r_mem_err   <= w_mem_err_nxt;
`ifdef MEM_ALIGN_CHECK_EN
         r_align_err <= w_align_err_nxt;
`endif
      end
   end

   assign mem_req      = r_mem_req;
   assign mem_we       = r_mem_we;
   assign mem_addr     = r_mem_addr;
   assign mem_wdata    = r_mem_wdata;
   assign wb_valid     = r_wb_valid;
   assign RegWrite_wb  = r_rw_wb;
   assign FlagWrite_wb = r_fw_wb;
   assign Rd_wb        = r_rd_wb;
   assign wb_data      = r_wb_data;
   assign mem_err      = r_mem_err;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage: transaction-level model of retire values, stall/req behaviour and sticky errors.
module tb_mem_access_stage;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, MemWrite, MemToReg, RegWrite, FlagWrite;
   logic [4:0]  Rd;
   logic [63:0] alu_result, Db, mem_rdata;
   logic        mem_ack;
   logic        stall, mem_req, mem_we, wb_valid, RegWrite_wb, FlagWrite_wb, mem_err;
   logic [63:0] mem_addr, mem_wdata, wb_data;
   logic [4:0]  Rd_wb;
`ifdef MEM_ALIGN_CHECK_EN
   logic        align_err;
`endif

   always #5 clk = ~clk;

   mem_access_stage #(.TIMEOUT(TO), .CNT_W(5)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .MemWrite(MemWrite), .MemToReg(MemToReg),
      .RegWrite(RegWrite), .FlagWrite(FlagWrite), .Rd(Rd), .alu_result(alu_result), .Db(Db),
      .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .wb_valid(wb_valid), .RegWrite_wb(RegWrite_wb),
      .FlagWrite_wb(FlagWrite_wb), .Rd_wb(Rd_wb), .wb_data(wb_data),
`ifdef MEM_ALIGN_CHECK_EN
      .align_err(align_err),
`endif
      .mem_err(mem_err)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Expected architectural view of the MEM/WB register
   logic        m_rw, m_fw, m_err, m_aerr, m_known;
   logic [4:0]  m_rd;
   logic [63:0] m_data;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic check_flags();
      check_val("mem_err", mem_err, m_err);
`ifdef MEM_ALIGN_CHECK_EN
      check_val("align_err", align_err, m_aerr);
`endif
   endtask

   task automatic model_reset();
      m_rw = 0; m_fw = 0; m_err = 0; m_aerr = 0; m_known = 1; m_rd = 0; m_data = 0;
   endtask

   // kind: 0 ALU, 1 load, 2 store, 3 both flags (store). delay = BUSY cycle index of ack, >= TO means never.
   task automatic do_op(input int kind, input logic rw, input logic fw, input logic [4:0] rd,
                        input logic [63:0] alu, input logic [63:0] db, input int delay,
                        input logic [63:0] rdata, input int gap);
      logic mw, mtr, is_mem, is_load, mis, acked;
      mw      = (kind == 2) || (kind == 3);
      mtr     = (kind == 1) || (kind == 3);
      is_mem  = mw | mtr;
      is_load = mtr & ~mw;
      mis     = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      mis = is_mem && (alu[2:0] != 3'b000);
`endif
      check_val("idle_stall", stall, 0);
      in_valid = 1; MemWrite = mw; MemToReg = mtr; RegWrite = rw; FlagWrite = fw;
      Rd = rd; alu_result = alu; Db = db;
      @(posedge clk); #1;
      in_valid = 0; alu_result = {$urandom, $urandom}; Db = {$urandom, $urandom};
      @(negedge clk);
      if (!is_mem) begin
         m_rw = rw; m_fw = fw; m_rd = rd; m_data = alu; m_known = 1;
      end else if (mis) begin
         m_rw = 0; m_fw = 0; m_aerr = 1; m_known = 0;
      end else begin
         acked = 0;
         for (int k = 0; k < TO; k++) begin
            check_val("busy_stall", stall, 1);
            check_val("busy_req", mem_req, 1);
            check_val("busy_we", mem_we, mw);
            check_val("busy_addr", mem_addr, alu);
            check_val("busy_wdata", mem_wdata, db);
            check_val("busy_wbv", wb_valid, 0);
            if (k == delay) begin
               mem_ack = 1; mem_rdata = rdata; acked = 1;
            end
            @(posedge clk); #1;
            mem_ack = 0; mem_rdata = {$urandom, $urandom};
            @(negedge clk);
            if (acked) break;
         end
         if (acked) begin
            m_rw = is_load ? rw : 1'b0; m_fw = fw; m_rd = rd;
            m_data = is_load ? rdata : alu; m_known = 1;
         end else begin
            m_rw = 0; m_fw = 0; m_err = 1; m_known = 0;
         end
      end
      check_val("done_stall", stall, 0);
      check_val("done_req", mem_req, 0);
      check_val("done_wbv", wb_valid, 1);
      check_val("done_rw", RegWrite_wb, m_rw);
      check_val("done_fw", FlagWrite_wb, m_fw);
      if (m_known) begin
         check_val("done_rd", Rd_wb, m_rd);
         check_val("done_data", wb_data, m_data);
      end
      check_flags();
      for (int g = 0; g < gap; g++) begin
         // Spurious/late acks in IDLE must not disturb anything
         if ($urandom_range(0, 1) == 0) mem_ack = 1;
         mem_rdata = {$urandom, $urandom};
         @(posedge clk); #1;
         mem_ack = 0;
         @(negedge clk);
         check_val("gap_wbv", wb_valid, 0);
         check_val("gap_stall", stall, 0);
         check_val("gap_req", mem_req, 0);
         check_val("gap_rw", RegWrite_wb, m_rw);
         check_val("gap_fw", FlagWrite_wb, m_fw);
         if (m_known) begin
            check_val("gap_rd", Rd_wb, m_rd);
            check_val("gap_data", wb_data, m_data);
         end
         check_flags();
      end
   endtask

   initial begin
      int kind, delay, r;
      logic [63:0] a;
      reset = 1; in_valid = 0; MemWrite = 0; MemToReg = 0; RegWrite = 0; FlagWrite = 0;
      Rd = 0; alu_result = 0; Db = 0; mem_rdata = 0; mem_ack = 0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_stall", stall, 0);
      check_val("rst_req", mem_req, 0);
      check_val("rst_we", mem_we, 0);
      check_val("rst_addr", mem_addr, 0);
      check_val("rst_wdata", mem_wdata, 0);
      check_val("rst_wbv", wb_valid, 0);
      check_val("rst_rw", RegWrite_wb, 0);
      check_val("rst_fw", FlagWrite_wb, 0);
      check_val("rst_rd", Rd_wb, 0);
      check_val("rst_data", wb_data, 0);
      check_flags();
      reset = 0;
      @(negedge clk);

      do_op(0, 1, 0, 5'd5, 64'h2A, 64'h0, 0, 64'h0, 1);
      do_op(1, 1, 1, 5'd7, 64'h100, 64'h0, 2, 64'hDEADBEEF, 1);
      do_op(2, 1, 0, 5'd3, 64'h8, 64'h55, 0, 64'h0, 0);
      do_op(0, 1, 1, 5'd9, 64'h1234, 64'h0, 0, 64'h0, 1);
      do_op(1, 1, 0, 5'd4, 64'h40, 64'h0, TO - 1, 64'hCAFE, 1);
      do_op(1, 1, 1, 5'd6, 64'h48, 64'h0, TO, 64'h0, 4);
      do_op(3, 1, 1, 5'd2, 64'h50, 64'h77, 1, 64'hBAD, 1);
`ifdef MEM_ALIGN_CHECK_EN
      do_op(1, 1, 1, 5'd1, 64'h103, 64'h0, 0, 64'h99, 1);
`endif

      for (int i = 0; i < 120; i++) begin
         kind = $urandom_range(0, 3);
         r = $urandom_range(0, 9);
         if (r < 6)      delay = $urandom_range(0, 4);
         else if (r < 8) delay = $urandom_range(5, TO - 1);
         else            delay = TO;
         a = {$urandom, $urandom};
         if ($urandom_range(0, 1) == 1) a[2:0] = 3'b000;
         do_op(kind, 1'($urandom), 1'($urandom), 5'($urandom), a, {$urandom, $urandom},
               delay, {$urandom, $urandom}, $urandom_range(0, 2));
      end

      // Asynchronous reset in the middle of a load
      in_valid = 1; MemWrite = 0; MemToReg = 1; RegWrite = 1; FlagWrite = 0; Rd = 5'd8;
      alu_result = 64'h200;
      @(posedge clk); #1;
      in_valid = 0;
      @(negedge clk);
      check_val("pre_rst_req", mem_req, 1);
      #2 reset = 1;
      #1;
      check_val("arst_req", mem_req, 0);
      check_val("arst_stall", stall, 0);
      check_val("arst_wbv", wb_valid, 0);
      check_val("arst_err", mem_err, 0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset = 0;
      @(negedge clk);
      check_val("post_rst_stall", stall, 0);
      check_val("post_rst_req", mem_req, 0);
      check_flags();
      do_op(0, 1, 1, 5'd11, 64'h5A5A, 64'h0, 0, 64'h0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
